decode_buffer: RTL and testbench

Parametrised instruction queue that replaces the single fetch→decode pipeline register with a DEPTH-entry FIFO carrying instruction/PC pairs under a valid/ready handshake. It sits between the fetch stage and the decode logic (instruction decoder, control unit, register file, branch decision). It absorbs fetch bursts while decode is stalled and presents a bubble instruction when empty. It supports whole-queue flush on branch redirect and an optional same-cycle bypass when empty.

---
 rtl/decode_pkg.sv | 13 +
 rtl/decode_buffer.sv | 93 +++++++++
 tb/tb_decode_buffer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared constants and payload type for the fetch-to-decode instruction queue.
package decode_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned ILEN         = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN-1:0]         instr;
        logic [XLEN_DEFAULT-1:0] pc;
    } decode_entry_t;

endpackage

// File: rtl/decode_buffer.sv
// DEPTH-entry instruction/PC queue between fetch and decode with flush and
// optional empty-queue bypass; drives a NOP bubble when nothing is valid.
module decode_buffer
    import decode_pkg::*;
#(
    parameter int unsigned     XLEN   = XLEN_DEFAULT,
    parameter int unsigned     DEPTH  = 4,
    parameter bit              BYPASS = 1'b0,
    parameter logic [ILEN-1:0] NOP    = NOP_INSTR
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid_f,
    input  logic [ILEN-1:0]            in_instr_f,
    input  logic [XLEN-1:0]            in_pc_f,
    output logic                       in_ready_f,
    input  logic                       stall_d,
    input  logic                       flush_d,
    output logic                       out_valid_d,
    output logic [ILEN-1:0]            instr_d,
    output logic [XLEN-1:0]            pc_d,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] rp;
    logic [AW-1:0] wp;
    logic          bypass_hit;
    logic          bypass_take;
    logic          push;
    logic          pop;
    entry_t        head;

    assign empty = (count == CW'(0));
    assign full  = (count == CW'(DEPTH));
    assign head  = mem[rp];

    // An empty queue may hand the fetch input straight to decode
    assign bypass_hit  = BYPASS && empty && in_valid_f && !flush_d;
    assign bypass_take = bypass_hit && !stall_d;

    assign in_ready_f = !full && !flush_d;
    assign push       = in_valid_f && in_ready_f && !bypass_take;
    assign pop        = !empty && !stall_d && !flush_d;

    // Output mux: stored head, bypassed input, or bubble
    always_comb begin
        out_valid_d = 1'b0;
        instr_d     = NOP;
        pc_d        = '0;
        if (!empty) begin
            out_valid_d = 1'b1;
            instr_d     = head.instr;
            pc_d        = head.pc;
        end else if (bypass_hit) begin
            out_valid_d = 1'b1;
            instr_d     = in_instr_f;
            pc_d        = in_pc_f;
        end
    end

    // Pointers and occupancy; flush returns everything to the origin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
        end else if (flush_d) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= '{instr: in_instr_f, pc: in_pc_f};
    end

endmodule

// File: tb/tb_decode_buffer.sv
// Directed bench for decode_buffer: one BYPASS=0 and one BYPASS=1 instance.
module tb_decode_buffer;
    import decode_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n;

    logic            in_valid_f, in_ready_f, stall_d, flush_d, out_valid_d, full, empty;
    logic [31:0]     in_instr_f, instr_d;
    logic [XLEN-1:0] in_pc_f, pc_d;
    logic [CW-1:0]   count;

    logic            b_in_valid_f, b_in_ready_f, b_stall_d, b_flush_d, b_out_valid_d, b_full, b_empty;
    logic [31:0]     b_in_instr_f, b_instr_d;
    logic [XLEN-1:0] b_in_pc_f, b_pc_d;
    logic [CW-1:0]   b_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    decode_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .BYPASS(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_f(in_valid_f), .in_instr_f(in_instr_f), .in_pc_f(in_pc_f),
        .in_ready_f(in_ready_f), .stall_d(stall_d), .flush_d(flush_d),
        .out_valid_d(out_valid_d), .instr_d(instr_d), .pc_d(pc_d),
        .count(count), .full(full), .empty(empty)
    );

    decode_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .BYPASS(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid_f(b_in_valid_f), .in_instr_f(b_in_instr_f), .in_pc_f(b_in_pc_f),
        .in_ready_f(b_in_ready_f), .stall_d(b_stall_d), .flush_d(b_flush_d),
        .out_valid_d(b_out_valid_d), .instr_d(b_instr_d), .pc_d(b_pc_d),
        .count(b_count), .full(b_full), .empty(b_empty)
    );

    // Inputs change on the falling edge; the rising edge commits them.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic st, input logic fl);
        in_valid_f = v; in_instr_f = ins; in_pc_f = pc; stall_d = st; flush_d = fl;
        #1;
    endtask

    task automatic test_reset();
        total++; if (out_valid_d !== 1'b0) $display("FAIL reset_valid got %0b want 0", out_valid_d); else passed++;
        total++; if (instr_d !== NOP_INSTR) $display("FAIL reset_instr got %h want %h", instr_d, NOP_INSTR); else passed++;
        total++; if (pc_d !== 32'h0) $display("FAIL reset_pc got %h want 0", pc_d); else passed++;
        total++; if (in_ready_f !== 1'b1) $display("FAIL reset_ready got %0b want 1", in_ready_f); else passed++;
        total++; if (full !== 1'b0) $display("FAIL reset_full got %0b want 0", full); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL reset_empty got %0b want 1", empty); else passed++;
        total++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else passed++;
    endtask

    task automatic test_single_push();
        drive(1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b0);
        total++; if (out_valid_d !== 1'b0) $display("FAIL single_same_cycle_valid got %0b want 0", out_valid_d); else passed++;
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        total++; if (out_valid_d !== 1'b1) $display("FAIL single_valid got %0b want 1", out_valid_d); else passed++;
        total++; if (instr_d !== 32'h0050_0093) $display("FAIL single_instr got %h want 00500093", instr_d); else passed++;
        total++; if (pc_d !== 32'h100) $display("FAIL single_pc got %h want 100", pc_d); else passed++;
        total++; if (count !== 3'd1) $display("FAIL single_count got %0d want 1", count); else passed++;
        tick();
        total++; if (instr_d !== 32'h0050_0093) $display("FAIL single_stall_hold got %h want 00500093", instr_d); else passed++;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        total++; if (empty !== 1'b1) $display("FAIL single_drain_empty got %0b want 1", empty); else passed++;
    endtask

    task automatic test_fill_stall();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h0000_00A0 + 32'(i), 32'h1000 + 32'(4 * i), 1'b1, 1'b0);
            total++;
            if (in_ready_f !== (i < 4)) $display("FAIL fill_ready[%0d] got %0b want %0b", i, in_ready_f, (i < 4));
            else passed++;
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        total++; if (full !== 1'b1) $display("FAIL fill_full got %0b want 1", full); else passed++;
        total++; if (count !== 3'd4) $display("FAIL fill_count got %0d want 4", count); else passed++;
        total++; if (instr_d !== 32'hA0) $display("FAIL fill_head_stable got %h want a0", instr_d); else passed++;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (instr_d !== 32'hA0 + 32'(i) || pc_d !== 32'h1000 + 32'(4 * i))
                $display("FAIL drain_order[%0d] got %h@%h want %h@%h", i, instr_d, pc_d,
                         32'hA0 + 32'(i), 32'h1000 + 32'(4 * i));
            else passed++;
            tick();
        end
        total++; if (instr_d !== NOP_INSTR) $display("FAIL drain_nop got %h want %h", instr_d, NOP_INSTR); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL drain_empty got %0b want 1", empty); else passed++;
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hB0 + 32'(i), 32'h2000 + 32'(4 * i), 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 32'hBF, 32'h2FFC, 1'b0, 1'b0);
        total++; if (in_ready_f !== 1'b0) $display("FAIL fullpp_ready got %0b want 0", in_ready_f); else passed++;
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        total++; if (count !== 3'd3) $display("FAIL fullpp_count got %0d want 3", count); else passed++;
        total++; if (instr_d !== 32'hB1) $display("FAIL fullpp_head got %h want b1", instr_d); else passed++;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick(); tick();
        total++; if (instr_d !== 32'hB3) $display("FAIL fullpp_last got %h want b3", instr_d); else passed++;
        tick();
        total++; if (empty !== 1'b1) $display("FAIL fullpp_no_extra got empty=%0b want 1", empty); else passed++;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hC0 + 32'(i), 32'h3000 + 32'(4 * i), 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 32'hCF, 32'h3FFC, 1'b1, 1'b1);
        total++; if (in_ready_f !== 1'b0) $display("FAIL flush_ready got %0b want 0", in_ready_f); else passed++;
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        total++; if (count !== 3'd0) $display("FAIL flush_count got %0d want 0", count); else passed++;
        total++; if (out_valid_d !== 1'b0) $display("FAIL flush_valid got %0b want 0", out_valid_d); else passed++;
        total++; if (pc_d !== 32'h0) $display("FAIL flush_pc got %h want 0", pc_d); else passed++;
        tick();
        total++; if (empty !== 1'b1) $display("FAIL flush_input_dropped got empty=%0b want 1", empty); else passed++;
    endtask

    task automatic test_wrap();
        // Two entries preloaded, then a steady stream keeps occupancy at two.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'hD0 + 32'(i), 32'h4000 + 32'(4 * i), 1'b1, 1'b0);
            tick();
        end
        for (int i = 2; i < 10; i++) begin
            drive(1'b1, 32'hD0 + 32'(i), 32'h4000 + 32'(4 * i), 1'b0, 1'b0);
            total++;
            if (instr_d !== 32'hD0 + 32'(i - 2) || pc_d !== 32'h4000 + 32'(4 * (i - 2)) || count !== 3'd2)
                $display("FAIL wrap[%0d] got %h@%h cnt %0d want %h@%h cnt 2", i, instr_d, pc_d, count,
                         32'hD0 + 32'(i - 2), 32'h4000 + 32'(4 * (i - 2)));
            else passed++;
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 8; i < 10; i++) begin
            total++;
            if (instr_d !== 32'hD0 + 32'(i)) $display("FAIL wrap_tail[%0d] got %h want %h", i, instr_d, 32'hD0 + 32'(i));
            else passed++;
            tick();
        end
        total++; if (empty !== 1'b1) $display("FAIL wrap_empty got %0b want 1", empty); else passed++;
    endtask

    task automatic test_bypass();
        b_in_valid_f = 1'b1; b_in_instr_f = 32'h0000_0463; b_in_pc_f = 32'h200; b_stall_d = 1'b0; b_flush_d = 1'b0;
        #1;
        total++; if (b_out_valid_d !== 1'b1) $display("FAIL byp_valid got %0b want 1", b_out_valid_d); else passed++;
        total++; if (b_instr_d !== 32'h463 || b_pc_d !== 32'h200) $display("FAIL byp_data got %h@%h want 463@200", b_instr_d, b_pc_d); else passed++;
        tick();
        b_in_valid_f = 1'b0;
        #1;
        total++; if (b_count !== 3'd0) $display("FAIL byp_count got %0d want 0", b_count); else passed++;
        total++; if (b_out_valid_d !== 1'b0) $display("FAIL byp_after_valid got %0b want 0", b_out_valid_d); else passed++;
        b_in_valid_f = 1'b1; b_stall_d = 1'b1;
        #1;
        total++; if (b_instr_d !== 32'h463) $display("FAIL byp_stall_data got %h want 463", b_instr_d); else passed++;
        tick();
        b_in_valid_f = 1'b0;
        #1;
        total++; if (b_count !== 3'd1) $display("FAIL byp_stall_count got %0d want 1", b_count); else passed++;
        total++; if (b_instr_d !== 32'h463 || b_pc_d !== 32'h200) $display("FAIL byp_stored got %h@%h want 463@200", b_instr_d, b_pc_d); else passed++;
        b_stall_d = 1'b0;
        tick();
        total++; if (b_empty !== 1'b1) $display("FAIL byp_drain got empty=%0b want 1", b_empty); else passed++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'hE0 + 32'(i), 32'h5000, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        total++; if (count !== 3'd0) $display("FAIL areset_count got %0d want 0", count); else passed++;
        total++; if (out_valid_d !== 1'b0 || instr_d !== NOP_INSTR) $display("FAIL areset_out got %0b/%h want 0/%h", out_valid_d, instr_d, NOP_INSTR); else passed++;
        tick();
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        total++; if (empty !== 1'b1) $display("FAIL areset_after got empty=%0b want 1", empty); else passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid_f = 1'b0; in_instr_f = '0; in_pc_f = '0; stall_d = 1'b0; flush_d = 1'b0;
        b_in_valid_f = 1'b0; b_in_instr_f = '0; b_in_pc_f = '0; b_stall_d = 1'b0; b_flush_d = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_single_push();
        test_fill_stall();
        test_full_push_pop();
        test_flush();
        test_wrap();
        test_bypass();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
